// File: rtl/layer_seq_pkg.sv
// rtl/layer_seq_pkg.sv - shared types, defaults and helpers for the layer sequencer
// Contents:
//   state_t          sequencer states IDLE / RUN / HOLD
//   DEF_*            default layer geometry
//   CAPTURE_CNT      counter value of the capture cycle at default geometry
//   capture_cnt()    capture counter value for any geometry
//   sat_hi/sat_lo()  signed saturation bounds for an OUT_BITS+1 bit result
package layer_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_NUM_NEURONS = 4;
    localparam int DEF_NEURON_BITS = 15;
    localparam int DEF_COUNTER_END = 3;
    localparam int DEF_PIPE_LAT    = 3;
    localparam int DEF_FRAC_SHIFT  = 4;
    localparam int DEF_OUT_BITS    = 15;

    localparam int CAPTURE_CNT = DEF_COUNTER_END + DEF_PIPE_LAT;

    // Last input element index plus the neuron pipeline depth: the cycle in
    // which every neuron output reflects the complete dot product.
    function automatic int capture_cnt(input int counter_end, input int pipe_lat);
        return counter_end + pipe_lat;
    endfunction

    function automatic longint sat_hi(input int out_bits);
        return (longint'(1) <<< out_bits) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int out_bits);
        return -(longint'(1) <<< out_bits);
    endfunction

endpackage

// File: rtl/layer_sequencer_requant_sat.sv
// rtl/layer_sequencer_requant_sat.sv - combinational arithmetic shift plus saturation of one neuron output
// Ports:
//   din   in   NEURON_BITS+9 bit signed neuron output
//   dout  out  OUT_BITS+1 bit signed requantized value
module requant_sat
    import layer_seq_pkg::*;
#(
    parameter int NEURON_BITS = DEF_NEURON_BITS,
    parameter int FRAC_SHIFT  = DEF_FRAC_SHIFT,
    parameter int OUT_BITS    = DEF_OUT_BITS
) (
    input  logic signed [NEURON_BITS+8:0] din,
    output logic signed [OUT_BITS:0]      dout
);

    localparam int NW = NEURON_BITS + 9;
    localparam logic signed [NW-1:0] HI = NW'(sat_hi(OUT_BITS));
    localparam logic signed [NW-1:0] LO = NW'(sat_lo(OUT_BITS));

    logic signed [NW-1:0] shifted;

    // >>> on a signed operand floors toward negative infinity.
    assign shifted = din >>> FRAC_SHIFT;

    always_comb begin
        dout = shifted[OUT_BITS:0];
        if (shifted > HI) begin
            dout = HI[OUT_BITS:0];
        end else if (shifted < LO) begin
            dout = LO[OUT_BITS:0];
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - sweeps a shared neuron counter, captures and requantizes one layer's outputs
// Ports:
//   clk         in   clock, rising edge
//   rstn        in   asynchronous reset, active-high
//   start       in   run one layer pass, sampled only in IDLE
//   busy        out  high in RUN and HOLD
//   counter     out  element/phase index broadcast to all neurons
//   neuron_out  in   per-neuron activated outputs
//   layer_out   out  registered requantized results
//   out_valid   out  layer_out valid
//   out_ready   in   downstream accepts layer_out
//   done        out  one-cycle pulse after the output handshake
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int NEURON_BITS = DEF_NEURON_BITS,
    parameter int COUNTER_END = DEF_COUNTER_END,
    parameter int PIPE_LAT    = DEF_PIPE_LAT,
    parameter int FRAC_SHIFT  = DEF_FRAC_SHIFT,
    parameter int OUT_BITS    = DEF_OUT_BITS
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    output logic                          busy,
    output logic [31:0]                   counter,
    input  logic signed [NEURON_BITS+8:0] neuron_out [0:NUM_NEURONS-1],
    output logic signed [OUT_BITS:0]      layer_out  [0:NUM_NEURONS-1],
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          done
);

    localparam logic [31:0] CAP_CNT = 32'(capture_cnt(COUNTER_END, PIPE_LAT));

    state_t state;

    logic signed [OUT_BITS:0] requant [0:NUM_NEURONS-1];

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_requant
        requant_sat #(
            .NEURON_BITS (NEURON_BITS),
            .FRAC_SHIFT  (FRAC_SHIFT),
            .OUT_BITS    (OUT_BITS)
        ) u_requant_sat (
            .din  (neuron_out[g]),
            .dout (requant[g])
        );
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= IDLE;
            counter   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                layer_out[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (counter == CAP_CNT) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            layer_out[i] <= requant[i];
                        end
                        counter   <= '0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        counter <= counter + 32'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    counter   <= '0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - directed self-checking bench for layer_sequencer
module tb_layer_sequencer;

    logic               clk;
    logic               rstn;
    logic               start;
    logic               busy;
    logic [31:0]        counter;
    logic signed [23:0] neuron_out [0:3];
    logic signed [15:0] layer_out  [0:3];
    logic               out_valid;
    logic               out_ready;
    logic               done;

    int tests_run;
    int tests_failed;

    layer_sequencer dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .busy       (busy),
        .counter    (counter),
        .neuron_out (neuron_out),
        .layer_out  (layer_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_neurons(input logic signed [23:0] a, input logic signed [23:0] b,
                               input logic signed [23:0] c, input logic signed [23:0] d);
        neuron_out[0] = a;
        neuron_out[1] = b;
        neuron_out[2] = c;
        neuron_out[3] = d;
    endtask

    // Pulses start for one cycle, then waits (bounded) until out_valid is seen.
    task automatic run_to_hold();
        bit seen;
        seen = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL run_to_hold_timeout: out_valid=%0b required 1 within 20 cycles", out_valid);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #3;
        tests_run++;
        if (counter !== 32'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: counter=%0d out_valid=%b busy=%b done=%b required 0/0/0/0",
                     counter, out_valid, busy, done);
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        logic signed [15:0] exp_out [0:3];
        exp_out = '{16'sd18, 16'sd1, 16'sd0, 16'sd0};
        set_neurons(24'h000120, 24'h000010, 24'h000000, 24'h00000F);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            tests_run++;
            if (counter !== 32'(i) || busy !== 1'b1 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL nominal_counter[%0d]: counter=%0d busy=%b out_valid=%b required %0d/1/0",
                         i, counter, busy, out_valid, i);
            end
            @(negedge clk);
        end
        tests_run++;
        if (out_valid !== 1'b1 || done !== 1'b0 || counter !== 32'd0) begin
            tests_failed++;
            $display("FAIL nominal_valid_t8: out_valid=%b done=%b counter=%0d required 1/0/0",
                     out_valid, done, counter);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (layer_out[i] !== exp_out[i]) begin
                tests_failed++;
                $display("FAIL nominal_layer_out[%0d]: got %0d required %0d", i, layer_out[i], exp_out[i]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL nominal_done_t9: done=%b out_valid=%b busy=%b required 1/0/0", done, out_valid, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL nominal_done_pulse: done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] exp_out [0:3];
        exp_out = '{16'sd32767, -16'sd32768, -16'sd2, 16'sd32767};
        set_neurons(24'h100000, 24'hF00000, 24'hFFFFEC, 24'h07FFF0);
        out_ready = 1'b1;
        run_to_hold();
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (layer_out[i] !== exp_out[i]) begin
                tests_failed++;
                $display("FAIL sat_layer_out[%0d]: got %0d required %0d", i, layer_out[i], exp_out[i]);
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic signed [15:0] exp_out [0:3];
        exp_out = '{16'sd2, -16'sd1, 16'sd100, 16'sd0};
        set_neurons(24'h000020, 24'hFFFFFF, 24'h000640, 24'h000005);
        out_ready = 1'b0;
        run_to_hold();
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            set_neurons(24'(c * 4096), 24'h7FFFFF, 24'h800000, 24'(c + 77));
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || counter !== 32'd0 || done !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: out_valid=%b counter=%0d done=%b busy=%b required 1/0/0/1",
                         c, out_valid, counter, done, busy);
            end
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (layer_out[i] !== exp_out[i]) begin
                    tests_failed++;
                    $display("FAIL bp_layer_out[%0d][%0d]: got %0d required %0d", c, i, layer_out[i], exp_out[i]);
                end
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: done=%b out_valid=%b required 1/0", done, out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_idle_after: busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int  dones;
        int  max_cnt;
        bit  prev_done;
        dones     = 0;
        max_cnt   = 0;
        prev_done = 1'b0;
        set_neurons(24'h000120, 24'h000010, 24'h000000, 24'h00000F);
        out_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (int'(counter) > max_cnt) max_cnt = int'(counter);
            if (prev_done) begin
                tests_run++;
                if (busy !== 1'b1 || counter !== 32'd0 || out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_restart[%0d]: busy=%b counter=%0d out_valid=%b required 1/0/0",
                             c, busy, counter, out_valid);
                end
            end
            if (done) begin
                dones++;
                tests_run++;
                if (c % 9 != 0 || busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_done_cycle: done at cycle %0d busy=%b required multiple of 9, busy 0", c, busy);
                end
            end
            prev_done = done;
        end
        start = 1'b0;
        tests_run++;
        if (dones != 4) begin
            tests_failed++;
            $display("FAIL b2b_done_count: got %0d required 4", dones);
        end
        tests_run++;
        if (max_cnt > 6) begin
            tests_failed++;
            $display("FAIL b2b_max_counter: got %0d required <= 6", max_cnt);
        end
        for (int i = 0; i < 12; i++) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit reached;
        reached = 1'b0;
        set_neurons(24'h000120, 24'h000010, 24'h000000, 24'h00000F);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            if (counter == 32'd3) reached = 1'b1;
            else @(negedge clk);
        end
        tests_run++;
        if (!reached) begin
            tests_failed++;
            $display("FAIL rst_mid_reach: counter=%0d required 3", counter);
        end
        #2;
        rstn = 1'b1;
        #1;
        tests_run++;
        if (counter !== 32'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: counter=%0d out_valid=%b busy=%b done=%b required 0/0/0/0",
                     counter, out_valid, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (layer_out[i] !== 16'sd0) begin
                tests_failed++;
                $display("FAIL rst_mid_layer_out[%0d]: got %0d required 0", i, layer_out[i]);
            end
        end
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_no_done[%0d]: done=%b out_valid=%b busy=%b required 0/0/0",
                         i, done, out_valid, busy);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        start        = 1'b0;
        out_ready    = 1'b0;
        rstn         = 1'b1;
        set_neurons(24'h0, 24'h0, 24'h0, 24'h0);

        test_reset();
        test_nominal();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Controls one fully-connected layer of neurons that share a common `counter`.
- Sweeps `counter` across all input elements plus the neuron pipeline latency, then captures every neuron's activated output.
- Requantizes each captured output (arithmetic shift plus saturation) to the next layer's data width.
- Presents the result vector downstream over a valid/ready handshake. Sits between the neuron array's `counter`/`data_out` and the next layer's `data_in`.

Parameters:
- NUM_NEURONS, 4, neurons in the layer; also the width of the output vector.
- NEURON_BITS, 15, neuron input MSB index; each neuron output is NEURON_BITS+9 bits signed.
- COUNTER_END, 3, index of the last input element (inputs 0..COUNTER_END).
- PIPE_LAT, 3, cycles from the last element to a valid neuron output (register → multiplier → adder → ReLu).
- FRAC_SHIFT, 4, arithmetic right shift applied at requantization.
- OUT_BITS, 15, output MSB index; each output is OUT_BITS+1 bits signed.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous reset, active-high (asserted = 1, despite the name).
- start  in  1  request to run one layer pass; sampled only in IDLE.
- busy  out  1  high in RUN and HOLD.
- counter  out  32  element/phase index broadcast to all neurons.
- neuron_out  in  [0:NUM_NEURONS-1] x (NEURON_BITS+9) signed  per-neuron data_out.
- layer_out  out  [0:NUM_NEURONS-1] x (OUT_BITS+1) signed  requantized results, registered.
- out_valid  out  1  layer_out valid.
- out_ready  in  1  downstream accepts layer_out.
- done  out  1  one-cycle pulse on handshake completion.

Behaviour:
- Reset (async, rstn=1): state IDLE, counter=0, layer_out all 0, out_valid=0, busy=0, done=0. Reset mid-pass aborts immediately; no partial capture survives.
- States: IDLE, RUN, HOLD.
- IDLE:
  - counter held at 0, busy=0.
  - start=1 at edge T → RUN, with counter=0 in cycle T+1.
- RUN:
  - counter increments by 1 per cycle.
  - The cycle where counter == COUNTER_END+PIPE_LAT (6 at defaults) is the capture cycle. At the end of that cycle:
    - neuron_out is requantized into layer_out;
    - counter returns to 0;
    - state → HOLD;
    - out_valid=1.
  - out_valid rises COUNTER_END+PIPE_LAT+2 cycles after start is sampled (8 at defaults).
  - start is ignored in RUN.
- HOLD:
  - out_valid=1; layer_out stable; counter=0.
  - On out_valid && out_ready: next cycle → IDLE, out_valid=0, done=1 for exactly one cycle.
  - start is ignored in HOLD, including during the handshake cycle. A new start is accepted from the first IDLE cycle, which may coincide with done=1.
  - out_ready may be held high in advance; the handshake then completes in the first HOLD cycle.
- Requantization, per neuron:
  - s = neuron_out >>> FRAC_SHIFT (arithmetic, floor toward −inf).
  - s > 2^OUT_BITS−1 → 2^OUT_BITS−1; s < −2^OUT_BITS → −2^OUT_BITS; otherwise s truncated to OUT_BITS+1 bits (lossless in range).
- The counter is 32 bits; wrap is unreachable because RUN is bounded by COUNTER_END+PIPE_LAT.

Decomposition:
- Package layer_seq_pkg:
  - state enum {IDLE, RUN, HOLD};
  - localparam CAPTURE_CNT = COUNTER_END+PIPE_LAT;
  - saturation bound constants as functions of OUT_BITS.
- Sub-module requant_sat: purely combinational shift+saturate for one value, parameterized by NEURON_BITS, FRAC_SHIFT, OUT_BITS. Instantiated NUM_NEURONS times via generate.
- The FSM, counter and capture registers live in the top module.

Test Plan:
- Reset/idle: rstn pulsed mid-RUN (counter=3) → next edge-independent: counter=0, out_valid=0, busy=0, layer_out=0; no done.
- Nominal pass with defaults: start at T, out_ready=1, neuron_out={0x000120, 0x000010, 0x000000, 0x00000F}.
  - counter reads 0..6 in T+1..T+7.
  - out_valid at T+8 with layer_out={18, 1, 0, 0}.
  - done=1 at T+9.
- Saturation/sign: neuron_out={0x100000, 0xF00000, 0xFFFFEC, 0x07FFF0} → layer_out={32767, −32768, −2, 32767}.
- Backpressure: out_ready=0 for 5 HOLD cycles while neuron_out changes → layer_out unchanged, counter=0, out_valid held. out_ready=1 → done one cycle later.
- Start filtering: start held high continuously → passes run back-to-back. Each new RUN begins in the cycle after IDLE is entered (the done cycle). No start is accepted during RUN/HOLD; counter never exceeds 6.
